// File: rtl/mcp320x_scan_spi.sv
// mcp320x_scan_spi: round-robin scanning SPI master for the MCP3204/MCP3208
// 12-bit ADC family. A free-running tick requests one conversion per TICK
// cycles; each frame is 1 start-bit setup phase plus 19 SCK periods. Results
// are presented on data/ch with a one-cycle dv strobe.
// Optional feature: define MCP320X_NULL_CHECK_EN to flag a non-zero null bit
// on err (sticky until reset). Without it err is constant 0.
module mcp320x_scan_spi #(
    parameter int unsigned FCLK    = 100_000_000,
    parameter int unsigned FSCK    = 500_000,
    parameter int unsigned FS      = 4_000,
    parameter int unsigned NCH     = 8,
    parameter bit          SGL     = 1'b1,
    parameter logic [7:0]  CH_MASK = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        miso,
    output logic        mosi,
    output logic        sck,
    output logic        cs,
    output logic [11:0] data,
    output logic [2:0]  ch,
    output logic        dv,
    output logic        err
);

    // Derived timing constants (cycles of clk)
    localparam int unsigned HALF = FCLK / (2 * FSCK);
    localparam int unsigned TICK = FCLK / FS;
    localparam longint unsigned CSH_L =
        (64'(FCLK) * 64'd500 + 64'd999_999_999) / 64'd1_000_000_000;
    localparam int unsigned CSH  = 32'(CSH_L);

    localparam int HW = $clog2(HALF + 1);
    localparam int TW = $clog2(TICK + 1);
    localparam int CW = $clog2(CSH + 1);

    // Channels above NCH do not exist on the part and are never scanned
    localparam logic [7:0] NCH_MASK = (NCH >= 8) ? 8'hFF : 8'((16'd1 << NCH) - 16'd1);
    localparam logic [7:0] EFF_MASK = CH_MASK & NCH_MASK;

    // Lowest enabled channel (0 when nothing is enabled)
    function automatic logic [2:0] lowest_ch(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Next enabled channel strictly above cur, wrapping to the lowest one
    function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] cur);
        logic [2:0] r;
        logic       found;
        r     = lowest_ch(m);
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && (i > int'(cur)) && m[i]) begin
                r     = 3'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    localparam logic [2:0] PTR_RST = lowest_ch(EFF_MASK);

    // Elaboration-time legality checks
    if ((FSCK < 32'd10_000) || (FSCK > 32'd900_000)) begin : g_bad_fsck
        $fatal(1, "mcp320x_scan_spi: FSCK out of range 10 kHz..900 kHz");
    end
    if (!((39 * HALF + CSH + 2) < TICK)) begin : g_bad_tick
        $fatal(1, "mcp320x_scan_spi: frame plus CS high time does not fit in one tick");
    end
    if ((NCH != 32'd4) && (NCH != 32'd8)) begin : g_bad_nch
        $fatal(1, "mcp320x_scan_spi: NCH must be 4 or 8");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [CW-1:0] csh_cnt_q, csh_cnt_d;
    logic [HW-1:0] half_cnt_q, half_cnt_d;
    logic [4:0]    edge_cnt_q, edge_cnt_d;
    logic          sck_q, sck_d;
    logic          cs_q, cs_d;
    logic          mosi_q, mosi_d;
    logic [11:0]   shreg_q, shreg_d;
    logic [11:0]   data_q, data_d;
    logic [2:0]    ch_q, ch_d;
    logic          dv_q, dv_d;
    logic          err_q, err_d;
    logic [2:0]    ptr_q, ptr_d;

    logic          tick_s;
    logic          half_end_s;
    logic          csh_ok_s;
    logic          start_s;
    logic [4:0]    edge_nx_s;
    logic [4:0]    cmd_s;

    assign tick_s     = (tick_cnt_q == TW'(TICK - 1));
    assign half_end_s = (half_cnt_q == HW'(HALF - 1));
    assign csh_ok_s   = (csh_cnt_q >= CW'(CSH));
    assign start_s    = tick_s && en && (EFF_MASK != 8'd0) && csh_ok_s;
    assign edge_nx_s  = edge_cnt_q + 5'd1;
    // Command shifted on rising edges 1..5: start, SGL/DIFF, D2, D1, D0
    assign cmd_s      = {1'b1, SGL, ptr_q};

    // Free-running conversion-rate tick counter
    always_comb begin
        if (tick_s) begin
            tick_cnt_d = TW'(0);
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end
    end

    // Measures how long cs has been high, saturating at the required minimum
    always_comb begin
        if (!cs_q) begin
            csh_cnt_d = CW'(0);
        end else if (!csh_ok_s) begin
            csh_cnt_d = csh_cnt_q + CW'(1);
        end else begin
            csh_cnt_d = csh_cnt_q;
        end
    end

    // Next-state logic for the frame sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) state_d = ST_SETUP;
                else         state_d = ST_IDLE;
            end
            ST_SETUP: begin
                if (half_end_s) state_d = ST_SHIFT;
                else            state_d = ST_SETUP;
            end
            ST_SHIFT: begin
                if (half_end_s && sck_q && (edge_cnt_q == 5'd19)) state_d = ST_DONE;
                else                                              state_d = ST_SHIFT;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values: SPI pins, shift register, result, pointer
    always_comb begin
        half_cnt_d = half_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sck_d      = sck_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        ch_d       = ch_q;
        dv_d       = 1'b0;
        ptr_d      = ptr_q;
`ifdef MCP320X_NULL_CHECK_EN
        err_d      = err_q;
`else
        err_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cs_d       = 1'b1;
                sck_d      = 1'b0;
                half_cnt_d = HW'(0);
                edge_cnt_d = 5'd0;
                if (start_s) begin
                    cs_d   = 1'b0;
                    mosi_d = 1'b1;
                end else begin
                    mosi_d = 1'b0;
                end
            end
            ST_SETUP: begin
                cs_d   = 1'b0;
                sck_d  = 1'b0;
                mosi_d = 1'b1;
                if (half_end_s) half_cnt_d = HW'(0);
                else            half_cnt_d = half_cnt_q + HW'(1);
            end
            ST_SHIFT: begin
                cs_d = 1'b0;
                if (!half_end_s) begin
                    half_cnt_d = half_cnt_q + HW'(1);
                end else if (!sck_q) begin
                    // Rising edge: ADC drives DOUT before it, so sample here
                    half_cnt_d = HW'(0);
                    sck_d      = 1'b1;
                    edge_cnt_d = edge_nx_s;
                    if (edge_nx_s >= 5'd8) shreg_d = {shreg_q[10:0], miso};
                    else                   shreg_d = shreg_q;
`ifdef MCP320X_NULL_CHECK_EN
                    if ((edge_nx_s == 5'd7) && miso) err_d = 1'b1;
                    else                             err_d = err_q;
`endif
                end else begin
                    // Falling edge: present the bit for the next rising edge
                    half_cnt_d = HW'(0);
                    sck_d      = 1'b0;
                    if (edge_cnt_q < 5'd5) mosi_d = cmd_s[3'd4 - edge_cnt_q[2:0]];
                    else                   mosi_d = 1'b0;
                    if (edge_cnt_q == 5'd19) cs_d = 1'b1;
                    else                     cs_d = 1'b0;
                end
            end
            ST_DONE: begin
                cs_d   = 1'b1;
                sck_d  = 1'b0;
                mosi_d = 1'b0;
                data_d = shreg_q;
                ch_d   = ptr_q;
                dv_d   = 1'b1;
                ptr_d  = next_ch(EFF_MASK, ptr_q);
            end
            default: begin
                cs_d   = 1'b1;
                sck_d  = 1'b0;
                mosi_d = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= TW'(0);
            csh_cnt_q  <= CW'(0);
            half_cnt_q <= HW'(0);
            edge_cnt_q <= 5'd0;
            sck_q      <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            shreg_q    <= 12'd0;
            data_q     <= 12'd0;
            ch_q       <= 3'd0;
            dv_q       <= 1'b0;
            err_q      <= 1'b0;
            ptr_q      <= PTR_RST;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            csh_cnt_q  <= csh_cnt_d;
            half_cnt_q <= half_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sck_q      <= sck_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            ch_q       <= ch_d;
            dv_q       <= dv_d;
            err_q      <= err_d;
            ptr_q      <= ptr_d;
        end
    end

    assign sck  = sck_q;
    assign cs   = cs_q;
    assign mosi = mosi_q;
    assign data = data_q;
    assign ch   = ch_q;
    assign dv   = dv_q;
    assign err  = err_q;

endmodule

// File: tb/tb_mcp320x_scan_spi.sv
// Bench for mcp320x_scan_spi: two instances (8-channel single-ended, full mask;
// 4-channel pseudo-differential, mask 8'h05) driven by an event-level ADC model.
// The model serves a random 12-bit word per frame and pushes the expected
// {err, ch, data} into a queue; a separate monitor pops on every dv.
module tb_mcp320x_scan_spi;

    localparam int unsigned FCLK = 10_000_000;
    localparam int unsigned FSCK = 500_000;
    localparam int unsigned FS   = 20_000;
    localparam int HALF = 10;   // FCLK / (2*FSCK)
    localparam int TICK = 500;  // FCLK / FS
    localparam int CSH  = 5;    // ceil(500 ns * FCLK)

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    logic   en    = 1'b0;
    longint cyc   = 0;
    int     checks   = 0;
    int     failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam logic [7:0]  MASK_G = (g == 0) ? 8'hFF : 8'h05;
        localparam bit          SGL_G  = (g == 0) ? 1'b1 : 1'b0;
        localparam int unsigned NCH_G  = (g == 0) ? 8 : 4;

        logic        miso_w = 1'b0;
        logic        mosi_w, sck_w, cs_w, dv_w, err_w;
        logic [11:0] data_w;
        logic [2:0]  ch_w;

        mcp320x_scan_spi #(
            .FCLK(FCLK), .FSCK(FSCK), .FS(FS), .NCH(NCH_G), .SGL(SGL_G), .CH_MASK(MASK_G)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .en(en), .miso(miso_w),
            .mosi(mosi_w), .sck(sck_w), .cs(cs_w),
            .data(data_w), .ch(ch_w), .dv(dv_w), .err(err_w)
        );

        string       pfx;
        int          en_list[$];
        logic [15:0] sb[$];
        int          rises = 0, frames = 0, ref_idx = 0, dv_cnt = 0, bad_per = 0, unstable = 0;
        logic [11:0] word = 12'd0;
        logic [4:0]  cmd = 5'd0;
        logic        null_b = 1'b0, err_seen = 1'b0;
        logic        cs_p = 1'b1, sck_p = 1'b0, rst_p = 1'b0;
        longint      t_fall = 0, t_rise = -1, t_lastr = 0, t_first = 0;

        // Enabled channel list in scan order, straight from the mask
        initial begin
            pfx = (g == 0) ? "A" : "B";
            for (int c = 0; c < int'(NCH_G); c++) begin
                if (MASK_G[c]) en_list.push_back(c);
            end
        end

        function automatic logic miso_bit(input int k, input logic [11:0] w, input logic nb);
            if (k == 7) return nb;
            else if (k >= 8 && k <= 19) return w[19-k];
            else return 1'($urandom);
        endfunction

        // ADC model: reacts to cs/sck/rst_n edges
        initial forever begin
            logic [2:0] ch_e;
            logic       err_e;
            @(cs_w or sck_w or rst_n);
            if (rst_n !== rst_p) begin
                if (rst_n === 1'b0) begin
                    ref_idx  = 0;
                    err_seen = 1'b0;
                end
                rst_p = rst_n;
            end
            if (sck_w !== sck_p) begin
                if (sck_w === 1'b1 && cs_w === 1'b0) begin
                    rises++;
                    if (rises == 1) t_first = cyc;
                    else if (cyc - t_lastr != 2 * HALF) bad_per++;
                    t_lastr = cyc;
                    if (rises <= 5) cmd = {cmd[3:0], mosi_w};
                    if (rises == 7) err_seen = err_seen | null_b;
                end else if (sck_w === 1'b0 && cs_w === 1'b0) begin
                    miso_w = miso_bit(rises + 1, word, null_b);
                end
                sck_p = sck_w;
            end
            if (cs_w !== cs_p) begin
                if (cs_w === 1'b0) begin
                    if (t_rise >= 0) chk({pfx, ".cs_high_min"}, longint'(cyc - t_rise >= CSH), 1);
                    frames++;
                    rises   = 0;
                    bad_per = 0;
                    cmd     = 5'd0;
                    word    = 12'($urandom_range(0, 4095));
                    null_b  = ($urandom_range(0, 3) == 0);
                    t_fall  = cyc;
                    miso_w  = 1'($urandom);
                end else if (cs_w === 1'b1) begin
                    t_rise = cyc;
                    if (rst_n === 1'b1 && frames > 0) begin
                        chk({pfx, ".rises_per_frame"}, rises, 19);
                        if (rises == 19) begin
                            ch_e = 3'(en_list[ref_idx]);
`ifdef MCP320X_NULL_CHECK_EN
                            err_e = err_seen;
`else
                            err_e = 1'b0;
`endif
                            chk({pfx, ".frame_len"}, cyc - t_fall, 39 * HALF);
                            chk({pfx, ".cs_to_sck"}, t_first - t_fall, 2 * HALF);
                            chk({pfx, ".sck_period_errs"}, bad_per, 0);
                            chk({pfx, ".mosi_cmd"}, cmd, {1'b1, SGL_G, ch_e});
                            sb.push_back({err_e, ch_e, word});
                            ref_idx = (ref_idx + 1) % en_list.size();
                        end
                    end
                end
                cs_p = cs_w;
            end
        end

        // Monitor: pops the scoreboard on every dv, checks latency and spacing
        initial begin
            logic        dv_prev = 1'b0, prev_ok = 1'b0;
            logic [11:0] last_data = 12'd0;
            logic [2:0]  last_ch = 3'd0;
            logic [15:0] exp_e;
            longint      last_dv = 0;
            forever begin
                @(negedge clk);
                if (rst_n !== 1'b1) begin
                    last_data = 12'd0;
                    last_ch   = 3'd0;
                    prev_ok   = 1'b0;
                end else if (dv_w === 1'b1) begin
                    dv_cnt++;
                    chk({pfx, ".dv_one_cycle"}, dv_prev, 0);
                    chk({pfx, ".dv_after_cs"}, cyc - t_rise, 1);
                    if (en && prev_ok) chk({pfx, ".dv_spacing"}, cyc - last_dv, TICK);
                    chk({pfx, ".dv_expected"}, longint'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        exp_e = sb.pop_front();
                        chk({pfx, ".ch"}, ch_w, exp_e[14:12]);
                        chk({pfx, ".data"}, data_w, exp_e[11:0]);
                        chk({pfx, ".err"}, err_w, exp_e[15]);
                    end
                    last_data = data_w;
                    last_ch   = ch_w;
                    last_dv   = cyc;
                    prev_ok   = en;
                end else begin
                    if (data_w !== last_data || ch_w !== last_ch) unstable++;
                    if (!en) prev_ok = 1'b0;
                end
                dv_prev = dv_w;
            end
        end
    end

    initial begin
        int t;
        int d0, d1, f0, f1;
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("A.reset_outputs",
            {g_dut[0].cs_w, g_dut[0].sck_w, g_dut[0].mosi_w, g_dut[0].dv_w, g_dut[0].err_w,
             g_dut[0].ch_w, g_dut[0].data_w}, 20'h80000);
        chk("B.reset_outputs",
            {g_dut[1].cs_w, g_dut[1].sck_w, g_dut[1].mosi_w, g_dut[1].dv_w, g_dut[1].err_w,
             g_dut[1].ch_w, g_dut[1].data_w}, 20'h80000);
        @(negedge clk);
        rst_n = 1'b1;

        // en low: no frames at all
        repeat (1500) @(negedge clk);
        chk("A.no_frame_en_low", g_dut[0].frames, 0);
        chk("B.no_frame_en_low", g_dut[1].frames, 0);

        // Scan: enough results to wrap 7->0 on A and 0,2,0,2 on B
        en = 1'b1;
        t = 0;
        while (!(g_dut[0].dv_cnt >= 10 && g_dut[1].dv_cnt >= 4) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("scan_timeout", longint'(t < 20000), 1);

        // Drop en at rising edge 10: frame completes, one dv, no new frame
        t = 0;
        while (g_dut[0].rises != 10 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("en_drop_timeout", longint'(t < 2000), 1);
        d0 = g_dut[0].dv_cnt;
        d1 = g_dut[1].dv_cnt;
        f0 = g_dut[0].frames;
        f1 = g_dut[1].frames;
        en = 1'b0;
        repeat (2000) @(negedge clk);
        chk("A.en_drop_one_dv", g_dut[0].dv_cnt, d0 + 1);
        chk("B.en_drop_one_dv", g_dut[1].dv_cnt, d1 + 1);
        chk("A.en_drop_no_frame", g_dut[0].frames, f0);
        chk("B.en_drop_no_frame", g_dut[1].frames, f1);
        chk("A.en_drop_cs_high", g_dut[0].cs_w, 1);

        // Reset at rising edge 12: outputs return at once, no dv, restart at lowest channel
        en = 1'b1;
        t = 0;
        while (g_dut[0].rises != 12 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("rst_mid_timeout", longint'(t < 2000), 1);
        d0 = g_dut[0].dv_cnt;
        rst_n = 1'b0;
        #1;
        chk("A.rst_async_cs", g_dut[0].cs_w, 1);
        chk("A.rst_async_sck", g_dut[0].sck_w, 0);
        chk("B.rst_async_cs", g_dut[1].cs_w, 1);
        chk("B.rst_async_sck", g_dut[1].sck_w, 0);
        repeat (20) @(negedge clk);
        chk("A.rst_no_dv", g_dut[0].dv_cnt, d0);
        chk("A.rst_data_ch", {g_dut[0].ch_w, g_dut[0].data_w}, 0);
        rst_n = 1'b1;
        t = 0;
        while (g_dut[0].dv_cnt < d0 + 1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("rst_restart_timeout", longint'(t < 3000), 1);
        chk("A.first_ch_after_rst", g_dut[0].ch_w, 0);
        chk("B.first_ch_after_rst", g_dut[1].ch_w, 0);

        // A few more conversions, then drain
        t = 0;
        while (g_dut[0].dv_cnt < d0 + 6 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("tail_timeout", longint'(t < 5000), 1);
        en = 1'b0;
        repeat (1000) @(negedge clk);
        chk("A.sb_drained", g_dut[0].sb.size(), 0);
        chk("B.sb_drained", g_dut[1].sb.size(), 0);
        chk("A.data_stable", g_dut[0].unstable, 0);
        chk("B.data_stable", g_dut[1].unstable, 0);
`ifndef MCP320X_NULL_CHECK_EN
        chk("A.err_tied_low", g_dut[0].err_w, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
